// File: rtl/dm_pkg.sv
// dm_pkg: op-code constants, arbiter state encoding and op helpers shared by the data-memory path.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package dm_pkg;

  localparam logic [3:0] OP_LW  = 4'b0000;
  localparam logic [3:0] OP_LB  = 4'b0001;
  localparam logic [3:0] OP_LBU = 4'b0010;
  localparam logic [3:0] OP_LH  = 4'b0011;
  localparam logic [3:0] OP_LHU = 4'b0100;
  localparam logic [3:0] OP_SB  = 4'b0101;
  localparam logic [3:0] OP_SH  = 4'b0110;
  localparam logic [3:0] OP_SW  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dm_state_e;

  // Op actually presented to the memory: loads never carry a store op code,
  // and any store that is not a byte/halfword store becomes a word store.
  function automatic logic [3:0] issue_op(input logic we, input logic [3:0] op);
    if (we) begin
      return (op == OP_SB || op == OP_SH) ? op : OP_SW;
    end
    return (op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU) ? op : OP_LW;
  endfunction

  // Alignment rule on the issued op: bytes anywhere, halfwords on even
  // addresses, everything else on word boundaries.
  function automatic logic misaligned(input logic [3:0] iop, input logic [1:0] off);
    case (iop)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LB, OP_LBU, OP_SB: return 1'b0;
      default:              return |off;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; a tie goes to the port that did not win last time.
// Latency: grant is combinational from req; last_gnt updates on the edge a grant is taken.
// Backpressure: gnt_en low blocks all grants and freezes the priority state.
module rr_arb2
  import dm_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       gnt_en,
  output logic       gnt_vld,
  output logic       gnt_id
);

  logic last_gnt;

  // Pick the single requester, or the one that is not last_gnt on a tie.
  always_comb begin
    gnt_vld = gnt_en & (|req);
    gnt_id  = 1'b0;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_gnt;
      default: gnt_id = 1'b0;
    endcase
  end

  // Remember the winner; reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_gnt <= 1'b1;
    end else if (gnt_vld) begin
      last_gnt <= gnt_id;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-ported data memory between the MEM stage (p0) and the debug/DMA loader (p1).
// Latency: req sampled in IDLE, memory driven the next cycle, one-cycle ack the cycle after; 1 txn per 3 cycles.
// Backpressure: req is a level held until ack and is sampled only in IDLE; the losing port simply waits.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [3:0]        p0_op,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [3:0]        p1_op,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              dm_we,
  output logic [3:0]        dm_op,
  output logic [1:0]        dm_byte,
  output logic [ADDR_W-3:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  dm_state_e         state_q;
  dm_state_e         state_d;
  logic              arb_en;
  logic              gnt_vld;
  logic              gnt_id;

  logic              lat_id;
  logic              lat_we;
  logic [3:0]        lat_op;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic              err_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic [3:0]        iss_op;
  logic              mis;
  logic [DATA_W-1:0] lane_wdata;

  assign arb_en = (state_q == IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     ({p1_req, p0_req}),
    .gnt_en  (arb_en),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  // State register; reset drops out of ACCESS at once so dm_we falls asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fixed IDLE -> ACCESS -> RESP walk; only IDLE waits on a grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the winner's request so later changes on its inputs are ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lat_id    <= 1'b0;
      lat_we    <= 1'b0;
      lat_op    <= OP_LW;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (gnt_vld) begin
      lat_id <= gnt_id;
      if (gnt_id) begin
        lat_we    <= p1_we;
        lat_op    <= p1_op;
        lat_addr  <= p1_addr;
        lat_wdata <= p1_wdata;
      end else begin
        lat_we    <= p0_we;
        lat_op    <= p0_op;
        lat_addr  <= p0_addr;
        lat_wdata <= p0_wdata;
      end
    end
  end

  // Issued op, alignment and lane replication; the memory takes an upper
  // halfword from [31:16] and byte lane n from [8n+7:8n].
  always_comb begin
    iss_op = issue_op(lat_we, lat_op);
    mis    = misaligned(iss_op, lat_addr[1:0]);
    case (iss_op)
      OP_SH:   lane_wdata = {2{lat_wdata[15:0]}};
      OP_SB:   lane_wdata = {4{lat_wdata[7:0]}};
      default: lane_wdata = lat_wdata;
    endcase
  end

  // Memory lines carry the latched request only in ACCESS and idle at zero otherwise.
  always_comb begin
    dm_we    = 1'b0;
    dm_op    = OP_LW;
    dm_byte  = 2'b00;
    dm_addr  = '0;
    dm_wdata = '0;
    if (state_q == ACCESS) begin
      dm_we    = lat_we & ~mis;
      dm_op    = iss_op;
      dm_byte  = lat_addr[1:0];
      dm_addr  = lat_addr[ADDR_W-1:2];
      dm_wdata = lane_wdata;
    end
  end

  // Close the access: record err and update the owner's rdata on loads or errors.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state_q == ACCESS) begin
      err_q <= mis;
      if (mis || !lat_we) begin
        if (lat_id) begin
          rdata1_q <= mis ? '0 : dm_rdata;
        end else begin
          rdata0_q <= mis ? '0 : dm_rdata;
        end
      end
    end
  end

  assign p0_ack   = (state_q == RESP) & ~lat_id;
  assign p1_ack   = (state_q == RESP) &  lat_id;
  assign p0_err   = p0_ack & err_q;
  assign p1_err   = p1_ack & err_q;
  assign p0_rdata = rdata0_q;
  assign p1_rdata = rdata1_q;

endmodule
